// File: rtl/spi_bus_pkg.sv
// ---------------------------------------------------------------------------
// spi_bus_pkg
// Shared definitions for the SPI bus arbiter and its byte shifter:
//   state_t      arbiter FSM state encoding
//   DEV_*        device index constants (flash, LED driver, SID)
//   SHIFT_STEPS  half-clock steps per byte (8 bits x 2 phases at clk/2)
//   GAP_CYCLES   cycles with every chip select high between bursts
// ---------------------------------------------------------------------------
package spi_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   localparam int DEV_FLASH = 0;
   localparam int DEV_LED   = 1;
   localparam int DEV_SID   = 2;

   localparam int SHIFT_STEPS = 16;
   localparam int GAP_CYCLES  = 2;

endpackage

// File: rtl/spi_byte_shifter.sv
// ---------------------------------------------------------------------------
// spi_byte_shifter
// Shifts one byte MSB-first in SPI mode 0 at clk/2.
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   start     begin a byte; tx_byte is loaded on the edge that sees start
//   tx_byte   byte to send; its MSB is presented on sdo while idle so the
//             first bit is already stable during setup
//   sdi       serial input, sampled on the edge that raises sck
//   sck       internal serial clock (steered to one device by the arbiter)
//   sdo       serial output
//   done      1-cycle pulse after the 16th step; rx_data updates with it
//   rx_data   last received byte, held until the next done
// ---------------------------------------------------------------------------
module spi_byte_shifter
   import spi_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       sdi,
   output logic       sck,
   output logic       sdo,
   output logic       done,
   output logic [7:0] rx_data
);

   localparam int STEP_W = $clog2(SHIFT_STEPS + 1);

   // step == 0 means idle; 1..SHIFT_STEPS is the current half-bit step
   logic [STEP_W-1:0] step;
   logic [7:0]        tx_sh;
   logic [7:0]        rx_sh;
   logic              sdo_r;
   logic              active;

   assign active = (step != '0);
   assign sdo    = active ? sdo_r : tx_byte[7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step    <= '0;
         sck     <= 1'b0;
         sdo_r   <= 1'b0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         done    <= 1'b0;
         rx_data <= '0;
      end else begin
         done <= 1'b0;
         if (!active) begin
            if (start) begin
               // step 1: sck low, present MSB, shift it out of the register
               step  <= STEP_W'(1);
               sck   <= 1'b0;
               sdo_r <= tx_byte[7];
               tx_sh <= {tx_byte[6:0], 1'b0};
            end
         end else if (step == STEP_W'(SHIFT_STEPS)) begin
            step    <= '0;
            sck     <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sh;
         end else if (step[0]) begin
            // odd -> even step: rising sck edge, capture sdi
            step  <= step + 1'b1;
            sck   <= 1'b1;
            rx_sh <= {rx_sh[6:0], sdi};
         end else begin
            // even -> odd step: falling sck edge, next bit onto sdo
            step  <= step + 1'b1;
            sck   <= 1'b0;
            sdo_r <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter
// Shares one byte-wide SPI shifter between N_REQ requesters (index 0 = CPU
// path), granting round-robin and holding chip select across bursts.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   req        per-requester level request, held until gnt
//   req_data   tx byte per requester (slice i = requester i)
//   req_dev    target device per requester, used on the first byte only
//   req_last   marks the byte as the final one of its burst
//   gnt        one-hot 1-cycle grant; req_data is captured on that edge
//   done       one-hot 1-cycle pulse when the owner's byte completes
//   err        1-cycle pulse for a bad device index or a lock timeout
//   rx_data    received byte, valid with done and held afterwards
//   busy       high whenever the FSM is not idle
//   sck, cs_b  per-device serial clock and active-low chip select
//   sdo, sdi   serial data out / in
// ---------------------------------------------------------------------------
module spi_bus_arbiter
   import spi_bus_pkg::*;
#(
   parameter int N_REQ        = 3,
   parameter int N_DEV        = DEV_SID + 1,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [2*N_REQ-1:0] req_dev,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic [N_REQ-1:0]   err,
   output logic [7:0]         rx_data,
   output logic               busy,
   output logic [N_DEV-1:0]   sck,
   output logic [N_DEV-1:0]   cs_b,
   output logic               sdo,
   input  logic               sdi
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [1:0]       dev;
   logic [7:0]       tx_byte;
   logic             last;
   logic             locked;
   logic             start;
   logic [TO_W-1:0]  hold_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic             any_req;
   logic [PTR_W-1:0] winner;
   logic [1:0]       win_dev;

   logic             sh_sck;
   logic             sh_sdo;
   logic             sh_done;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   // Round-robin pick: scanning from the far end down means the last match
   // written is the one closest to rr_ptr.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % N_REQ]) begin
            any_req = 1'b1;
            winner  = PTR_W'((int'(rr_ptr) + k) % N_REQ);
         end
      end
   end

   assign win_dev = req_dev[2*winner +: 2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         dev      <= '0;
         tx_byte  <= '0;
         last     <= 1'b0;
         locked   <= 1'b0;
         start    <= 1'b0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         gnt      <= '0;
         err      <= '0;
      end else begin
         gnt   <= '0;
         err   <= '0;
         start <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A requester still shows req during its own gnt cycle, so
               // skip that cycle to avoid granting it twice.
               if (any_req && gnt == '0) begin
                  gnt[winner] <= 1'b1;
                  rr_ptr      <= next_ptr(winner);
                  tx_byte     <= req_data[8*winner +: 8];
                  last        <= req_last[winner];
                  if (int'(win_dev) >= N_DEV) begin
                     err[winner] <= 1'b1;
                  end else begin
                     owner  <= winner;
                     dev    <= win_dev;
                     locked <= 1'b1;
                     state  <= ST_SETUP;
                  end
               end
            end

            ST_SETUP: begin
               start <= 1'b1;
               state <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (sh_done) begin
                  if (last) begin
                     locked  <= 1'b0;
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else if (req[owner]) begin
                     // next byte already waiting: regrant without HOLD/SETUP
                     gnt[owner] <= 1'b1;
                     tx_byte    <= req_data[8*owner +: 8];
                     last       <= req_last[owner];
                     start      <= 1'b1;
                  end else begin
                     hold_cnt <= '0;
                     state    <= ST_HOLD;
                  end
               end
            end

            ST_HOLD: begin
               if (req[owner]) begin
                  gnt[owner] <= 1'b1;
                  tx_byte    <= req_data[8*owner +: 8];
                  last       <= req_last[owner];
                  start      <= 1'b1;
                  state      <= ST_SHIFT;
               end else if (hold_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                  err[owner] <= 1'b1;
                  locked     <= 1'b0;
                  gap_cnt    <= '0;
                  state      <= ST_GAP;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            ST_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   spi_byte_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_byte (tx_byte),
      .sdi     (sdi),
      .sck     (sh_sck),
      .sdo     (sh_sdo),
      .done    (sh_done),
      .rx_data (rx_data)
   );

   // Only the locked device sees chip select and clock; all others idle.
   always_comb begin
      sck  = '0;
      cs_b = '1;
      for (int d = 0; d < N_DEV; d++) begin
         if (locked && int'(dev) == d) begin
            cs_b[d] = 1'b0;
            sck[d]  = sh_sck;
         end
      end
   end

   always_comb begin
      done = '0;
      if (sh_done) begin
         done[owner] = 1'b1;
      end
   end

   assign sdo  = locked & sh_sdo;
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
`timescale 1ns/1ps
module tb_spi_bus_arbiter;
   import spi_bus_pkg::*;

   localparam int N_REQ        = 3;
   localparam int N_DEV        = 3;
   localparam int LOCK_TIMEOUT = 255;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_REQ-1:0]    req;
   logic [8*N_REQ-1:0]  req_data;
   logic [2*N_REQ-1:0]  req_dev;
   logic [N_REQ-1:0]    req_last;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic [N_REQ-1:0]    err;
   logic [7:0]          rx_data;
   logic                busy;
   logic [N_DEV-1:0]    sck;
   logic [N_DEV-1:0]    cs_b;
   logic                sdo;
   logic                sdi;

   assign sdi = sdo;

   always #5 clk = ~clk;

   spi_bus_arbiter #(
      .N_REQ        (N_REQ),
      .N_DEV        (N_DEV),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .req_dev  (req_dev),
      .req_last (req_last),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .rx_data  (rx_data),
      .busy     (busy),
      .sck      (sck),
      .cs_b     (cs_b),
      .sdo      (sdo),
      .sdi      (sdi)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         gnt_who[$];
   int         gnt_at[$];
   logic [2:0] gnt_err[$];
   int         done_at[$];
   logic [7:0] done_rx[$];
   int         err_at[$];
   int         err_who[$];
   int         sck_rise[N_DEV];
   int         first_rise;
   int         sdo_bad;
   logic [N_DEV-1:0] sck_prev;
   logic             sdo_prev;

   logic [7:0] qbytes[N_REQ][4];
   int         qn[N_REQ];
   int         qpos[N_REQ];

   // One clock; sample #1 after the edge, log events, and let each
   // requester present its next burst byte or drop req when granted.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < N_DEV; d++) begin
         if (sck[d] && !sck_prev[d]) begin
            sck_rise[d]++;
            if (first_rise < 0) first_rise = cyc;
         end
      end
      if (sdo !== sdo_prev && sck !== '0) sdo_bad++;
      sck_prev = sck;
      sdo_prev = sdo;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_who.push_back(i);
            gnt_at.push_back(cyc);
            gnt_err.push_back(err);
            if (qpos[i] < qn[i] - 1) begin
               qpos[i]++;
               req_data[8*i +: 8] = qbytes[i][qpos[i]];
               req_last[i] = (qpos[i] == qn[i] - 1);
            end else begin
               req[i] = 1'b0;
            end
         end
         if (done[i]) begin
            done_at.push_back(cyc);
            done_rx.push_back(rx_data);
         end
         if (err[i]) begin
            err_at.push_back(cyc);
            err_who.push_back(i);
         end
      end
   endtask

   task automatic clear_log();
      gnt_who.delete();
      gnt_at.delete();
      gnt_err.delete();
      done_at.delete();
      done_rx.delete();
      err_at.delete();
      err_who.delete();
      for (int d = 0; d < N_DEV; d++) sck_rise[d] = 0;
      first_rise = -1;
      sdo_bad    = 0;
   endtask

   task automatic load_req(input int i, input logic [1:0] dv, input int n,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
      qbytes[i][0] = b0;
      qbytes[i][1] = b1;
      qbytes[i][2] = b2;
      qn[i]   = n;
      qpos[i] = 0;
      req_data[8*i +: 8] = b0;
      req_dev[2*i +: 2]  = dv;
      req_last[i] = (n == 1);
      req[i] = 1'b1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!busy && req == '0) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0; req_last = '0; req_data = '0; req_dev = '0;
      for (int i = 0; i < N_REQ; i++) begin qn[i] = 0; qpos[i] = 0; end
      sck_prev = '0; sdo_prev = 1'b0;
      clear_log();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", done); end
      checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", err); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (sck !== 3'b000) begin errors++; $display("FAIL reset_sck: got %b expected 000", sck); end
      checks++; if (cs_b !== 3'b111) begin errors++; $display("FAIL reset_cs_b: got %b expected 111", cs_b); end
      checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", sdo); end
   endtask

   task automatic test_single();
      int t0, g, dn, cs_bad;
      bit ok;
      clear_log();
      cs_bad = 0;
      load_req(0, 2'(DEV_FLASH), 1, 8'hA5, 8'h00, 8'h00);
      t0 = cyc;
      for (int k = 0; k < 10 && gnt_at.size() == 0; k++) step();
      g = (gnt_at.size() > 0) ? gnt_at[0] : -1;
      checks++; if (g != t0 + 1) begin errors++; $display("FAIL single_gnt_latency: got cycle %0d expected %0d", g, t0 + 1); end
      checks++; if (gnt_who.size() != 1 || gnt_who[0] != 0) begin errors++; $display("FAIL single_gnt_who: got %0d grants expected 1 to requester 0", gnt_who.size()); end
      for (int k = 0; k < 40 && done_at.size() == 0; k++) begin
         if (cs_b !== 3'b110) cs_bad++;
         step();
      end
      dn = (done_at.size() > 0) ? done_at[0] : -1;
      checks++; if (dn - g != 18) begin errors++; $display("FAIL single_done_latency: got %0d expected 18", dn - g); end
      checks++; if (done_rx.size() != 1 || done_rx[0] !== 8'hA5) begin errors++; $display("FAIL single_rx: got %h expected a5", rx_data); end
      checks++; if (first_rise - g != 3) begin errors++; $display("FAIL single_first_sck: got %0d expected 3", first_rise - g); end
      checks++; if (sck_rise[0] != 8 || sck_rise[1] != 0 || sck_rise[2] != 0) begin errors++; $display("FAIL single_sck_rises: got %0d/%0d/%0d expected 8/0/0", sck_rise[0], sck_rise[1], sck_rise[2]); end
      checks++; if (cs_bad != 0) begin errors++; $display("FAIL single_cs_b: got %0d bad cycles expected 0", cs_bad); end
      checks++; if (sdo_bad != 0) begin errors++; $display("FAIL single_sdo_phase: got %0d changes with sck high expected 0", sdo_bad); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_idle: got busy expected idle"); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_hold: got %h expected a5", rx_data); end
   endtask

   task automatic test_contention();
      int ord;
      bit ok;
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_log();
      load_req(0, 2'(DEV_FLASH), 1, 8'h01, 8'h00, 8'h00);
      load_req(1, 2'(DEV_LED),   1, 8'h02, 8'h00, 8'h00);
      load_req(2, 2'(DEV_SID),   1, 8'h04, 8'h00, 8'h00);
      for (int k = 0; k < 200 && done_at.size() < 3; k++) step();
      ord = (gnt_who.size() == 3) ? gnt_who[0]*16 + gnt_who[1]*4 + gnt_who[2] : -1;
      checks++; if (ord != 6) begin errors++; $display("FAIL contention_order_ptr0: got code %0d expected 6 (0,1,2)", ord); end
      wait_idle(ok);
      // one request from 0 moves the pointer to 1
      load_req(0, 2'(DEV_FLASH), 1, 8'h10, 8'h00, 8'h00);
      for (int k = 0; k < 10 && req[0]; k++) step();
      wait_idle(ok);
      clear_log();
      load_req(0, 2'(DEV_FLASH), 1, 8'h01, 8'h00, 8'h00);
      load_req(1, 2'(DEV_LED),   1, 8'h02, 8'h00, 8'h00);
      load_req(2, 2'(DEV_SID),   1, 8'h04, 8'h00, 8'h00);
      for (int k = 0; k < 200 && done_at.size() < 3; k++) step();
      ord = (gnt_who.size() == 3) ? gnt_who[0]*16 + gnt_who[1]*4 + gnt_who[2] : -1;
      checks++; if (ord != 24) begin errors++; $display("FAIL contention_order_ptr1: got code %0d expected 24 (1,2,0)", ord); end
      checks++;
      if (done_rx.size() != 3 || {done_rx[0], done_rx[1], done_rx[2]} !== 24'h020401) begin
         errors++; $display("FAIL contention_rx: got %0d bytes expected 02,04,01", done_rx.size());
      end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL contention_idle: got busy expected idle"); end
   endtask

   task automatic test_burst();
      int ord, cs1_bad;
      bit ok;
      clear_log();
      cs1_bad = 0;
      load_req(1, 2'(DEV_LED),   3, 8'h11, 8'h22, 8'h33);
      load_req(0, 2'(DEV_FLASH), 1, 8'h5A, 8'h00, 8'h00);
      for (int k = 0; k < 300 && done_at.size() < 4; k++) begin
         step();
         if (gnt_at.size() > 0 && done_at.size() < 3 && cs_b[1] !== 1'b0) cs1_bad++;
      end
      checks++;
      if (gnt_who.size() != 4 || done_at.size() != 4) begin
         errors++; $display("FAIL burst_counts: got %0d grants %0d dones expected 4 and 4", gnt_who.size(), done_at.size());
      end else begin
         ord = ((gnt_who[0]*4 + gnt_who[1])*4 + gnt_who[2])*4 + gnt_who[3];
         checks++; if (ord != 84) begin errors++; $display("FAIL burst_order: got code %0d expected 84 (1,1,1,0)", ord); end
         checks++; if (gnt_at[1] - done_at[0] != 1) begin errors++; $display("FAIL burst_regrant: got %0d expected 1", gnt_at[1] - done_at[0]); end
         checks++; if (gnt_at[3] <= done_at[2] + 2) begin errors++; $display("FAIL burst_gap: got gnt0 %0d cycles after last done expected more than 2", gnt_at[3] - done_at[2]); end
         checks++;
         if ({done_rx[0], done_rx[1], done_rx[2], done_rx[3]} !== 32'h1122335A) begin
            errors++; $display("FAIL burst_rx: got %h %h %h %h expected 11 22 33 5a", done_rx[0], done_rx[1], done_rx[2], done_rx[3]);
         end
      end
      checks++; if (cs1_bad != 0) begin errors++; $display("FAIL burst_cs_b: got %0d cycles with cs_b[1] high expected 0", cs1_bad); end
      checks++; if (sdo_bad != 0) begin errors++; $display("FAIL burst_sdo_phase: got %0d expected 0", sdo_bad); end
      wait_idle(ok);
   endtask

   task automatic test_bad_dev();
      int act;
      clear_log();
      act = 0;
      load_req(2, 2'd3, 1, 8'h77, 8'h00, 8'h00);
      for (int k = 0; k < 8; k++) begin
         step();
         if (busy !== 1'b0 || sck !== 3'b000 || cs_b !== 3'b111) act++;
      end
      checks++; if (gnt_who.size() != 1 || gnt_who[0] != 2) begin errors++; $display("FAIL bad_dev_gnt: got %0d grants expected 1 to requester 2", gnt_who.size()); end
      checks++; if (gnt_err.size() < 1 || gnt_err[0] !== 3'b100) begin errors++; $display("FAIL bad_dev_err: got err size %0d expected 100 with gnt", gnt_err.size()); end
      checks++; if (err_at.size() != 1) begin errors++; $display("FAIL bad_dev_err_count: got %0d expected 1", err_at.size()); end
      checks++; if (act != 0) begin errors++; $display("FAIL bad_dev_activity: got %0d active cycles expected 0", act); end
      checks++; if (done_at.size() != 0) begin errors++; $display("FAIL bad_dev_done: got %0d expected 0", done_at.size()); end
   endtask

   task automatic test_timeout();
      int hold_bad, e;
      bit ok;
      clear_log();
      hold_bad = 0;
      load_req(0, 2'(DEV_FLASH), 2, 8'hC3, 8'h3C, 8'h00);
      for (int k = 0; k < 10 && gnt_at.size() == 0; k++) step();
      req[0] = 1'b0;
      for (int k = 0; k < 400 && err_at.size() == 0; k++) begin
         step();
         if (done_at.size() > 0 && err_at.size() == 0 && cs_b !== 3'b110) hold_bad++;
      end
      e = (err_at.size() > 0 && done_at.size() > 0) ? err_at[0] - done_at[0] : -1;
      checks++; if (e != 256) begin errors++; $display("FAIL timeout_latency: got %0d expected 256", e); end
      checks++; if (err_who.size() != 1 || err_who[0] != 0) begin errors++; $display("FAIL timeout_err_who: got %0d errs expected 1 on requester 0", err_who.size()); end
      checks++; if (cs_b !== 3'b111) begin errors++; $display("FAIL timeout_cs_release: got %b expected 111", cs_b); end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL timeout_hold_cs: got %0d bad cycles expected 0", hold_bad); end
      checks++; if (gnt_at.size() != 1 || done_at.size() != 1) begin errors++; $display("FAIL timeout_counts: got %0d grants %0d dones expected 1 and 1", gnt_at.size(), done_at.size()); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("FAIL timeout_idle: got busy expected idle"); end
   endtask

   task automatic test_reset_mid();
      clear_log();
      load_req(1, 2'(DEV_SID), 1, 8'hFF, 8'h00, 8'h00);
      for (int k = 0; k < 10 && gnt_at.size() == 0; k++) step();
      repeat (8) step();
      checks++; if (cs_b !== 3'b011 || sck_rise[2] != 3) begin errors++; $display("FAIL midrst_pre: got cs_b %b rises %0d expected 011 and 3", cs_b, sck_rise[2]); end
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (cs_b !== 3'b111) begin errors++; $display("FAIL midrst_cs_b: got %b expected 111", cs_b); end
      checks++; if (sck !== 3'b000) begin errors++; $display("FAIL midrst_sck: got %b expected 000", sck); end
      checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL midrst_sdo: got %b expected 0", sdo); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx: got %h expected 00", rx_data); end
      checks++; if ({gnt, done, err} !== 9'b0) begin errors++; $display("FAIL midrst_pulses: got %b expected 0", {gnt, done, err}); end
      step();
      step();
      rst = 1'b0;
      repeat (30) step();
      checks++; if (done_at.size() != 0 || err_at.size() != 0) begin errors++; $display("FAIL midrst_no_done: got %0d dones %0d errs expected 0", done_at.size(), err_at.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_burst();
      test_bad_dev();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
